stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control sequencer for the MM:SS:hh stopwatch datapath: debounces the three push-button keys and runs the start/pause/lap/clear/preset state machine. It generates the 10 ms timebase tick that enables the counter chain, plus synchronous clear and minute-preset load strobes. It also produces a display-freeze (lap) flag and an alarm on minute-counter wrap. It sits between board I/O (KEY, SW, LEDR) and the mod-k counter chain and HEX display drivers.

Parameters:
TICK_DIV, 500000, CLOCK_50 cycles per tick (10 ms at 50 MHz)
TICK_W, 19, divider counter width; must hold TICK_DIV-1
DEB_CYCLES, 1000000, cycles a synchronized key level must be stable before acceptance (20 ms)
DEB_W, 20, debounce counter width
MAX_MIN, 60, preset values >= MAX_MIN load as 0

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; sampled on CLOCK_50 rising edge
key_start_n  in  1  raw start/stop key, active-low, asynchronous
key_lap_n  in  1  raw lap/clear key, active-low, asynchronous
key_preset_n  in  1  raw preset key, active-low, asynchronous
preset_val  in  6  minute preset from switches
wrap_in  in  1  one-cycle pulse from the minute counter on 59->0 wrap
tick  out  1  one-cycle enable pulse every TICK_DIV cycles while running
run  out  1  high in RUN or LAP
clr  out  1  one-cycle synchronous clear to all counters
load  out  1  one-cycle minute-counter load strobe
load_val  out  6  clamped preset value, valid while load=1
freeze  out  1  high in LAP; display holds last value
alarm  out  1  high in DONE (drives LEDR[0])
state  out  3  IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4

Behaviour:
- Reset: state=IDLE; tick=0; clr=1 for the reset cycle and 0 afterwards; load=0; load_val=0; divider=0.
  - Debounce state is set to "released" with counters at 0.
  - A key held across reset produces no press event.
- Per key:
  - 2-FF synchronizer feeds a debounce counter.
  - The debounced level flips only after the synchronized level differs from it for DEB_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - Press event = one-cycle pulse on debounced 1->0.
  - Releases generate nothing.
  - Press event is visible DEB_CYCLES+2 edges after raw level first sampled low.
  - State/strobes update on the following edge: total latency DEB_CYCLES+3.
- Event priority in one cycle: reset > wrap_in > start > lap > preset. Lower-priority events in the same cycle are dropped, not queued.
- Transitions (all others hold state):
  - IDLE: start->RUN; preset->load pulse, stay IDLE; lap ignored.
  - RUN: start->PAUSE; lap->LAP; wrap_in->DONE; preset ignored.
  - LAP: lap->RUN (freeze drops); start->PAUSE (freeze drops); wrap_in->DONE.
  - PAUSE: start->RUN; lap->IDLE with clr pulse; preset->load pulse, stay PAUSE.
  - DONE: lap->IDLE with clr pulse; start, preset, wrap_in ignored.
- wrap_in in IDLE/PAUSE is ignored.
- Outputs run, freeze, alarm, state: combinational decode of the state register.
- tick, clr, load, load_val: registered.
- Divider:
  - Increments each cycle while in RUN or LAP.
  - At TICK_DIV-1 it wraps to 0 and tick=1 for exactly that following cycle.
  - Holds its value in PAUSE/DONE, so resume continues the partial period.
  - Cleared to 0 on clr and reset.
- Preset clamp: load_val = preset_val if preset_val < MAX_MIN else 0. load and clr never assert together.
- Reset asserted mid-run forces IDLE the next edge regardless of key/tick activity.

Test Plan:
Use DEB_CYCLES=4, TICK_DIV=5.
1. reset 2 cycles, keys high -> state=0, run=0, tick never asserts over 50 cycles, clr high only during reset cycles.
2. key_start_n low, held 20 cycles -> state=1 at edge 7 after first low sample. tick pulses every 5 cycles (first 5 cycles after run rises). Exactly one press event while held.
3. In RUN, start after 2 divider counts, then start again -> PAUSE, no tick while paused. After resume, the first tick arrives 3 cycles after run rises.
4. Glitchy start key (low 3 cycles, high 1, low 3) -> no state change. Then a steady 6-cycle low -> one press.
5. In PAUSE: preset with preset_val=45 -> load=1, load_val=45. Repeat with preset_val=63 -> load_val=0. Lap -> state=0, clr one cycle.
6. RUN, lap -> freeze=1, state=3, ticks continue. wrap_in pulse -> state=4, alarm=1, run=0. Start -> no change. Lap -> IDLE, clr, alarm=0. Start and lap debounced on same cycle in RUN -> PAUSE only.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Control sequencer for the MM:SS:hh stopwatch: key debounce, run-state FSM,
// 10 ms timebase tick and clear/preset strobes for the counter chain.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 500000,
  parameter int TICK_W     = 19,
  parameter int DEB_CYCLES = 1000000,
  parameter int DEB_W      = 20,
  parameter int MAX_MIN    = 60
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  input  logic       key_preset_n,
  input  logic [5:0] preset_val,
  input  logic       wrap_in,
  output logic       tick,
  output logic       run,
  output logic       clr,
  output logic       load,
  output logic [5:0] load_val,
  output logic       freeze,
  output logic       alarm,
  output logic [2:0] state
);

  localparam int NKEY     = 3;
  localparam int K_START  = 0;
  localparam int K_LAP    = 1;
  localparam int K_PRESET = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [NKEY-1:0]   key_raw;
  logic [NKEY-1:0]   press;
  logic              clr_d, load_d;
  logic              running;
  logic              preset_ok;
  logic [5:0]        preset_clamped;
  logic [TICK_W-1:0] div_q;

  assign key_raw = {key_preset_n, key_lap_n, key_start_n};

  // Synchronizers are deliberately not reset so they still track a key held
  // during reset; 'armed' then suppresses the press such a key would cause.
  for (genvar g = 0; g < NKEY; g++) begin : g_key
    logic             sync1, sync2;
    logic             level, armed, press_q;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge CLOCK_50) begin
      sync1 <= key_raw[g];
      sync2 <= sync1;
    end

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        level   <= 1'b1;
        armed   <= 1'b0;
        press_q <= 1'b0;
        cnt     <= '0;
      end else begin
        press_q <= 1'b0;
        armed   <= armed | sync2;
        if (sync2 != level) begin
          if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
            level   <= sync2;
            cnt     <= '0;
            press_q <= armed & ~sync2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign press[g] = press_q;
  end

  assign running        = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign preset_ok      = 32'(preset_val) < 32'(MAX_MIN);
  assign preset_clamped = preset_ok ? preset_val : '0;

  // Only the highest-priority event of a cycle is acted on; the rest are lost.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    load_d  = 1'b0;
    if (wrap_in) begin
      if (running) state_d = ST_DONE;
    end else if (press[K_START]) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_LAP:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end else if (press[K_LAP]) begin
      case (state_q)
        ST_RUN:   state_d = ST_LAP;
        ST_LAP:   state_d = ST_RUN;
        ST_PAUSE: begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
        ST_DONE:  begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
        default:  state_d = state_q;
      endcase
    end else if (press[K_PRESET]) begin
      if (state_q == ST_IDLE || state_q == ST_PAUSE) load_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      clr      <= 1'b1;
      load     <= 1'b0;
      load_val <= '0;
    end else begin
      state_q  <= state_d;
      clr      <= clr_d;
      load     <= load_d;
      load_val <= load_d ? preset_clamped : '0;
    end
  end

  // Divider holds outside RUN/LAP so a resume finishes the partial period.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_q <= '0;
      tick  <= 1'b0;
    end else if (clr_d) begin
      div_q <= '0;
      tick  <= 1'b0;
    end else if (running) begin
      if (div_q == TICK_W'(TICK_DIV - 1)) begin
        div_q <= '0;
        tick  <= 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  assign run    = running;
  assign freeze = (state_q == ST_LAP);
  assign alarm  = (state_q == ST_DONE);
  assign state  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed plan plus random key/wrap/reset traffic,
// every cycle compared against a sliding-window / transition-table model.
module tb_stopwatch_ctrl;

  localparam int TD = 5;
  localparam int DB = 4;
  localparam int MM = 60;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       key_start_n = 1'b1;
  logic       key_lap_n = 1'b1;
  logic       key_preset_n = 1'b1;
  logic [5:0] preset_val = '0;
  logic       wrap_in = 1'b0;
  logic       tick, run, clr, load, freeze, alarm;
  logic [5:0] load_val;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  stopwatch_ctrl #(
    .TICK_DIV  (TD),
    .TICK_W    (3),
    .DEB_CYCLES(DB),
    .DEB_W     (3),
    .MAX_MIN   (MM)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .key_start_n (key_start_n),
    .key_lap_n   (key_lap_n),
    .key_preset_n(key_preset_n),
    .preset_val  (preset_val),
    .wrap_in     (wrap_in),
    .tick        (tick),
    .run         (run),
    .clr         (clr),
    .load        (load),
    .load_val    (load_val),
    .freeze      (freeze),
    .alarm       (alarm),
    .state       (state)
  );

  // next state per [state][event], event 0=wrap 1=start 2=lap 3=preset, -1 = no effect
  int nxt [5][4] = '{'{-1, 1, -1, 0}, '{4, 2, 3, -1}, '{-1, 1, 0, 2},
                     '{4, 2, 1, -1}, '{-1, -1, 0, -1}};

  int         m_state = 0, m_div = 0, m_lv = 0, post = 0;
  bit         m_tick = 0, m_clr = 0, m_load = 0;
  logic [15:0] hist [3];
  bit         lvl [3], arm [3], ev [3];

  int edge_no = 0, rise_edge = 0, first_tick = 0;
  int tick_cnt = 0, clr_cnt = 0, load_cnt = 0, last_lv = 0;
  bit run_prev = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // raw[k]: 0=start 1=lap 2=preset, as sampled at this edge
  task automatic model_edge(input logic r, input logic [2:0] raw, input logic w, input int pv);
    int  e, ns;
    bit  was_run, all0, all1, fresh;
    for (int k = 0; k < 3; k++) hist[k] = {hist[k][14:0], raw[k]};
    if (r) begin
      m_state = 0; m_clr = 1; m_load = 0; m_lv = 0; m_tick = 0; m_div = 0; post = 0;
      for (int k = 0; k < 3; k++) begin lvl[k] = 1; arm[k] = 0; ev[k] = 0; end
    end else begin
      e = -1;
      if (w) e = 0;
      else if (ev[0]) e = 1;
      else if (ev[1]) e = 2;
      else if (ev[2]) e = 3;
      ns = (e >= 0) ? nxt[m_state][e] : -1;
      was_run = (m_state == 1) || (m_state == 3);
      m_clr  = (e == 2) && (ns == 0);
      m_load = (e == 3) && (ns >= 0);
      m_lv   = m_load ? ((pv < MM) ? pv : 0) : 0;
      m_tick = 0;
      if (m_clr) m_div = 0;
      else if (was_run) begin
        m_div++;
        if (m_div == TD) begin m_div = 0; m_tick = 1; end
      end
      if (ns >= 0) m_state = ns;
      // a key level is accepted once DB consecutive synchronized samples agree
      post++;
      for (int k = 0; k < 3; k++) begin
        all0 = 1; all1 = 1;
        for (int j = 0; j < DB; j++) begin
          if (hist[k][2+j]) all0 = 0; else all1 = 0;
        end
        fresh = arm[k];
        arm[k] = arm[k] | hist[k][2];
        ev[k] = 0;
        if (post >= DB) begin
          if (lvl[k] && all0) begin lvl[k] = 0; ev[k] = fresh; end
          else if (!lvl[k] && all1) lvl[k] = 1;
        end
      end
    end
  endtask

  task automatic step();
    logic r, ks, kl, kp, w;
    int   pv;
    r = reset; ks = key_start_n; kl = key_lap_n; kp = key_preset_n; w = wrap_in;
    pv = int'(preset_val);
    @(posedge CLOCK_50);
    #1;
    edge_no++;
    model_edge(r, {kp, kl, ks}, w, pv);
    chk("state", 32'(state), 32'(m_state));
    chk("run", 32'(run), 32'((m_state == 1) || (m_state == 3)));
    chk("freeze", 32'(freeze), 32'(m_state == 3));
    chk("alarm", 32'(alarm), 32'(m_state == 4));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("clr", 32'(clr), 32'(m_clr));
    chk("load", 32'(load), 32'(m_load));
    if (m_load) chk("load_val", 32'(load_val), 32'(m_lv));
    if (tick) tick_cnt++;
    if (clr) clr_cnt++;
    if (load) begin load_cnt++; last_lv = int'(load_val); end
    if (run && !run_prev) begin rise_edge = edge_no; first_tick = 0; end
    if (tick && first_tick == 0) first_tick = edge_no;
    run_prev = run;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_start_n = v;
      1: key_lap_n = v;
      default: key_preset_n = v;
    endcase
  endtask

  task automatic press(input int k, input int hold, input int settle);
    set_key(k, 1'b0);
    repeat (hold) step();
    set_key(k, 1'b1);
    repeat (settle) step();
  endtask

  initial begin
    int   e0, t0, c0, l0;
    int   seg [3];
    logic kv [3];
    for (int k = 0; k < 3; k++) hist[k] = '1;

    // reset, then idle with keys released
    reset = 1'b1;
    step(); step();
    chk("rst_clr", 32'(clr), 1);
    chk("rst_state", 32'(state), 0);
    chk("rst_load_val", 32'(load_val), 0);
    reset = 1'b0;
    t0 = tick_cnt;
    step();
    chk("clr_after_rst", 32'(clr), 0);
    repeat (49) step();
    chk("idle_ticks", tick_cnt - t0, 0);

    // start held 20 cycles
    key_start_n = 1'b0;
    e0 = edge_no;
    repeat (20) step();
    chk("start_latency", rise_edge - e0, DB + 3);
    chk("first_tick_delay", first_tick - rise_edge, TD);
    chk("held_one_press", 32'(state), 1);
    key_start_n = 1'b1;
    repeat (10) step();

    // pause with the divider at 2, then resume
    for (int i = 0; i < TD && ((m_div + DB + 3) % TD) != 2; i++) step();
    press(0, 6, 1);
    chk("paused", 32'(state), 2);
    t0 = tick_cnt;
    repeat (12) step();
    chk("pause_ticks", tick_cnt - t0, 0);
    press(0, 6, 10);
    chk("resumed", 32'(state), 1);
    chk("resume_tick_delay", first_tick - rise_edge, 3);

    // glitchy key, then a clean 6-cycle press
    key_start_n = 1'b0; repeat (3) step();
    key_start_n = 1'b1; step();
    key_start_n = 1'b0; repeat (3) step();
    key_start_n = 1'b1; repeat (10) step();
    chk("glitch_ignored", 32'(state), 1);
    press(0, 6, 10);
    chk("steady_press", 32'(state), 2);

    // presets in PAUSE, then lap clears to IDLE
    l0 = load_cnt; last_lv = -1; preset_val = 6'd45;
    press(2, 6, 10);
    chk("load_count_45", load_cnt - l0, 1);
    chk("load_val_45", last_lv, 45);
    chk("stay_pause", 32'(state), 2);
    l0 = load_cnt; last_lv = -1; preset_val = 6'd63;
    press(2, 6, 10);
    chk("load_count_63", load_cnt - l0, 1);
    chk("load_val_63", last_lv, 0);
    c0 = clr_cnt;
    press(1, 6, 10);
    chk("lap_to_idle", 32'(state), 0);
    chk("lap_clr_pulses", clr_cnt - c0, 1);

    // RUN -> LAP -> DONE -> IDLE
    press(0, 6, 10);
    chk("idle_start", 32'(state), 1);
    press(1, 6, 10);
    chk("lap_state", 32'(state), 3);
    chk("lap_freeze", 32'(freeze), 1);
    t0 = tick_cnt;
    repeat (10) step();
    chk("lap_ticks", tick_cnt - t0, 2);
    wrap_in = 1'b1; step(); wrap_in = 1'b0;
    chk("wrap_done", 32'(state), 4);
    chk("wrap_alarm", 32'(alarm), 1);
    chk("wrap_run", 32'(run), 0);
    press(0, 6, 10);
    chk("done_start_ignored", 32'(state), 4);
    c0 = clr_cnt;
    press(1, 6, 10);
    chk("done_lap_idle", 32'(state), 0);
    chk("done_alarm_off", 32'(alarm), 0);
    chk("done_clr_pulses", clr_cnt - c0, 1);
    press(0, 6, 10);
    key_start_n = 1'b0; key_lap_n = 1'b0;
    repeat (6) step();
    key_start_n = 1'b1; key_lap_n = 1'b1;
    repeat (10) step();
    chk("start_beats_lap", 32'(state), 2);

    // key held across reset gives no press
    key_start_n = 1'b0; reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (15) step();
    chk("held_through_reset", 32'(state), 0);
    key_start_n = 1'b1;
    repeat (10) step();
    press(0, 6, 10);
    chk("press_after_release", 32'(state), 1);

    // reset in the middle of RUN
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrun_reset_state", 32'(state), 0);
    chk("midrun_reset_clr", 32'(clr), 1);
    step();

    // random key bounce/press, wrap and reset traffic
    for (int k = 0; k < 3; k++) begin kv[k] = 1'b1; seg[k] = int'($urandom_range(1, 9)); end
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (seg[k] == 0) begin
          kv[k] = ~kv[k];
          set_key(k, kv[k]);
          seg[k] = int'($urandom_range(1, 9));
        end else begin
          seg[k]--;
        end
      end
      wrap_in    = ($urandom_range(0, 29) == 0);
      reset      = ($urandom_range(0, 149) == 0);
      preset_val = 6'($urandom_range(0, 63));
      step();
    end
    reset = 1'b0; wrap_in = 1'b0;
    key_start_n = 1'b1; key_lap_n = 1'b1; key_preset_n = 1'b1;
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
